// File: rtl/id_checksum_checker.sv
// id_checksum_checker: letter + NUM_DIGITS digit ID frame checker.
// Weighted checksum mod 10, error cause, saturating legal-ID counter.
//
// Ports:
//   clk, rst          clock (rising edge), async active-high reset
//   in_valid, in_id   symbol stream; slot 0 letter 10..35, slots 1..N digits
//   out_valid         one-cycle result pulse, one cycle after the frame ends
//   out_legal_id      checksum legal and no bad symbol (qualified)
//   out_err           0 none, 1 bad symbol, 2 short frame (qualified)
//   legal_cnt         saturating count of legal IDs
module id_checksum_checker #(
  parameter int NUM_DIGITS = 9,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [5:0]       in_id,
  output logic             out_valid,
  output logic             out_legal_id,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] legal_cnt
);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  localparam logic [3:0]       LAST    = 4'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Letter contribution table: tens*1 + ones*9, mod 10.
  function automatic logic [3:0] letter_val(input logic [5:0] l);
    letter_val = '0;
    for (int k = 10; k < 36; k++)
      if (l == 6'(k))
        letter_val = 4'((k / 10 + (k % 10) * 9) % 10);
  endfunction

  // Constant product table: (d * w) mod 10 for d, w in 0..9.
  function automatic logic [3:0] mul10(
    input logic [3:0] d,
    input logic [3:0] w
  );
    mul10 = '0;
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        if (d == 4'(a) && w == 4'(b))
          mul10 = 4'((a * b) % 10);
  endfunction

  function automatic logic [3:0] add10(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    add10 = (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction

  state_t           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  logic [3:0]       sum_q, sum_d;
  logic             bad_q, bad_d;
  logic             valid_d, legal_d;
  logic [1:0]       err_d;
  logic [CNT_W-1:0] cnt_d;

  logic       letter_bad;
  logic       digit_bad;
  logic [3:0] w_raw;
  logic [3:0] weight;
  logic [3:0] digit_c;
  logic [3:0] sum_add;
  logic       bad_add;

  assign letter_bad = (in_id < 6'd10) || (in_id > 6'd35);
  assign digit_bad  = in_id > 6'd9;

  // Slots 1..N-1 weigh (N - slot) mod 10; the final slot weighs 1.
  assign w_raw   = LAST - slot_q;
  assign weight  = (slot_q == LAST) ? 4'd1 :
                   (w_raw >= 4'd10) ? w_raw - 4'd10 : w_raw;
  assign digit_c = digit_bad ? 4'd0 : mul10(in_id[3:0], weight);
  assign sum_add = add10(sum_q, digit_c);
  assign bad_add = bad_q | digit_bad;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sum_d   = sum_q;
    bad_d   = bad_q;
    valid_d = 1'b0;
    legal_d = 1'b0;
    err_d   = 2'd0;
    cnt_d   = legal_cnt;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = COLLECT;
          slot_d  = 4'd1;
          sum_d   = letter_bad ? 4'd0 : letter_val(in_id);
          bad_d   = letter_bad;
        end
      end
      COLLECT: begin
        if (!in_valid) begin
          // Abort: short frame outranks any bad symbol seen so far.
          state_d = IDLE;
          slot_d  = '0;
          sum_d   = '0;
          bad_d   = 1'b0;
          valid_d = 1'b1;
          err_d   = 2'd2;
        end else if (slot_q == LAST) begin
          state_d = IDLE;
          slot_d  = '0;
          sum_d   = '0;
          bad_d   = 1'b0;
          valid_d = 1'b1;
          err_d   = bad_add ? 2'd1 : 2'd0;
          legal_d = (sum_add == 4'd0) && !bad_add;
          if (legal_d && legal_cnt != CNT_MAX)
            cnt_d = legal_cnt + 1'b1;
        end else begin
          slot_d = slot_q + 4'd1;
          sum_d  = sum_add;
          bad_d  = bad_add;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      sum_q        <= '0;
      bad_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_legal_id <= 1'b0;
      out_err      <= 2'd0;
      legal_cnt    <= '0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      sum_q        <= sum_d;
      bad_q        <= bad_d;
      out_valid    <= valid_d;
      out_legal_id <= legal_d;
      out_err      <= err_d;
      legal_cnt    <= cnt_d;
    end
  end

endmodule
